// File: rtl/mm_result_accumulator.sv
// Per-lane signed accumulation of sign-magnitude multiplier products; result is presented at packet end.
// Latency: result valid the cycle after the last beat is accepted. Backpressure: in_ready drops while a result waits for out_ready.
module mm_result_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_mul,
  input  logic [3:0]         in_sign,
  input  logic               in_last,
  input  logic [1:0]         convtypeD,
  input  logic [1:0]         convtypeW,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] out_acc,
  output logic [3:0]         out_ovf,
  output logic [2:0]         out_lanes,
  output logic [CNT_W-1:0]   out_beats
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_d [4];
  logic [3:0]              ovf_q, ovf_d;
  logic [2:0]              lanes_q, lanes_d;
  logic [CNT_W-1:0]        beats_q, beats_d;

  logic                    accept;
  logic                    first;
  logic [2:0]              mode_lanes;
  logic [2:0]              lanes_eff;
  logic signed [ACC_W:0]   base_x [4];
  logic signed [ACC_W:0]   mag_x [4];
  logic signed [ACC_W:0]   sum_x [4];
  logic signed [ACC_W-1:0] nxt_acc [4];
  logic [3:0]              nxt_ovf;

  always_comb begin
    case ({convtypeD, convtypeW})
      4'b1111: mode_lanes = 3'd1;
      4'b1110: mode_lanes = 3'd2;
      4'b1010: mode_lanes = 3'd2;
      default: mode_lanes = 3'd4;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign first     = (state_q == IDLE);
  // Mode is only taken from the first beat; later beats reuse the latched lane count.
  assign lanes_eff = first ? mode_lanes : lanes_q;

  always_comb begin
    nxt_ovf = '0;
    for (int k = 0; k < 4; k++) begin
      base_x[k]  = first ? '0 : {acc_q[k][ACC_W-1], acc_q[k]};
      mag_x[k]   = {{(ACC_W-15){1'b0}}, in_mul[16*k +: 16]};
      sum_x[k]   = in_sign[k] ? (base_x[k] - mag_x[k]) : (base_x[k] + mag_x[k]);
      nxt_acc[k] = sum_x[k][ACC_W-1:0];
      if (sum_x[k][ACC_W] != sum_x[k][ACC_W-1]) begin
        nxt_acc[k] = sum_x[k][ACC_W] ? ACC_MIN : ACC_MAX;
        nxt_ovf[k] = 1'b1;
      end
      if (3'(k) >= lanes_eff) begin
        nxt_acc[k] = '0;
        nxt_ovf[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    lanes_d = lanes_q;
    beats_d = beats_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = in_last ? HOLD : ACCUM;
          acc_d   = nxt_acc;
          ovf_d   = (first ? 4'b0 : ovf_q) | nxt_ovf;
          lanes_d = lanes_eff;
          beats_d = first ? CNT_W'(1) : beats_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          for (int k = 0; k < 4; k++) acc_d[k] = '0;
          ovf_d   = '0;
          lanes_d = '0;
          beats_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
      ovf_q   <= '0;
      lanes_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      lanes_q <= lanes_d;
      beats_q <= beats_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_ovf   = ovf_q;
  assign out_lanes = lanes_q;
  assign out_beats = beats_q;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_acc[g*ACC_W +: ACC_W] = acc_q[g];
  end

endmodule
